// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and sizing helper for the clock gate controller.
// Included by every file of the clock_gate_ctrl slice.
package clock_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REQ   = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } gate_state_t;

    // Width wide enough to hold max(idle, wake) - 1, never narrower than one bit.
    function automatic int cnt_width(input int idle, input int wake);
        int m;
        m = (idle > wake) ? idle : wake;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/clock_gate_ctrl_if.sv
// Sleep handshake and clock-enable bundle between the controller and the gated domain.
// master = controller side, slave = gated domain / environment side.
interface clock_gate_ctrl_if;

    logic ENABLE;
    logic ACTIVITY;
    logic SLEEP_ACK;
    logic SLEEP_REQ;
    logic CLK_EN;
    logic CLK_READY;
    logic GATED;

    modport master (
        input  ENABLE, ACTIVITY, SLEEP_ACK,
        output SLEEP_REQ, CLK_EN, CLK_READY, GATED
    );

    modport slave (
        output ENABLE, ACTIVITY, SLEEP_ACK,
        input  SLEEP_REQ, CLK_EN, CLK_READY, GATED
    );

endinterface

// File: rtl/clock_gate_ctrl_sat_counter.sv
// Saturating up-counter, cleared by RST and holding at all-ones.
// Used for the optional gating statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK_IN,
    input  logic             RST,
    input  logic             INC,
    output logic [WIDTH-1:0] VALUE
);

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            VALUE <= '0;
        end else if (INC && (VALUE != '1)) begin
            VALUE <= VALUE + WIDTH'(1);
        end
    end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Activity-based CLK_EN controller with sleep request/acknowledge handshake.
// Optional statistics counters are built when CLOCK_GATE_STATS_EN is defined.
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES   = 64,
    parameter int WAKEUP_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 CLK_IN,
    input  logic                 RST,
    clock_gate_ctrl_if.master    bus
`ifdef CLOCK_GATE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] GATE_EVENTS,
    output logic [CNT_WIDTH-1:0] GATED_CYCLES
`endif
);

    localparam int CW = cnt_width(IDLE_CYCLES, WAKEUP_CYCLES);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKEUP_CYCLES - 1);

    gate_state_t   state, state_nxt;
    logic [CW-1:0] idle_cnt, idle_nxt;
    logic [CW-1:0] wake_cnt, wake_nxt;
    logic          wake_req;
    logic          clk_en_d, clk_ready_d, sleep_req_d, gated_d;

    assign wake_req = bus.ACTIVITY || !bus.ENABLE;

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        case (state)
            RUN: begin
                if (wake_req) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state_nxt = REQ;
                end else begin
                    idle_nxt = idle_cnt + CW'(1);
                end
            end
            REQ: begin
                // An abort wins over an acknowledge arriving in the same cycle.
                if (wake_req) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                end else if (bus.SLEEP_ACK) begin
                    state_nxt = GATED;
                end
            end
            GATED: begin
                if (wake_req) begin
                    state_nxt = WAKE;
                    wake_nxt  = WAKE_LOAD;
                end
            end
            WAKE: begin
                if (wake_cnt == '0) begin
                    state_nxt = RUN;
                    idle_nxt  = '0;
                end else begin
                    wake_nxt = wake_cnt - CW'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        clk_en_d    = 1'b1;
        clk_ready_d = 1'b1;
        sleep_req_d = 1'b0;
        gated_d     = 1'b0;
        case (state)
            REQ: sleep_req_d = 1'b1;
            GATED: begin
                clk_en_d    = 1'b0;
                clk_ready_d = 1'b0;
                sleep_req_d = 1'b1;
                gated_d     = 1'b1;
            end
            WAKE:    clk_ready_d = 1'b0;
            default: ;
        endcase
    end

    // Outputs come straight from flops so CLK_EN only moves on a rising edge.
    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            bus.CLK_EN    <= 1'b1;
            bus.CLK_READY <= 1'b1;
            bus.SLEEP_REQ <= 1'b0;
            bus.GATED     <= 1'b0;
        end else begin
            bus.CLK_EN    <= clk_en_d;
            bus.CLK_READY <= clk_ready_d;
            bus.SLEEP_REQ <= sleep_req_d;
            bus.GATED     <= gated_d;
        end
    end

`ifdef CLOCK_GATE_STATS_EN
    logic gate_evt;

    assign gate_evt = (state == REQ) && (state_nxt == GATED);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_gate_events (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .INC    (gate_evt),
        .VALUE  (GATE_EVENTS)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_gated_cycles (
        .CLK_IN (CLK_IN),
        .RST    (RST),
        .INC    (bus.GATED),
        .VALUE  (GATED_CYCLES)
    );
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with IDLE_CYCLES=8, WAKEUP_CYCLES=3.
// Statistics checks are compiled in when CLOCK_GATE_STATS_EN is defined.
module tb_clock_gate_ctrl;

    logic CLK_IN = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    clock_gate_ctrl_if bus ();

`ifdef CLOCK_GATE_STATS_EN
    logic [15:0] GATE_EVENTS;
    logic [15:0] GATED_CYCLES;
`endif

    clock_gate_ctrl #(
        .IDLE_CYCLES   (8),
        .WAKEUP_CYCLES (3),
        .CNT_WIDTH     (16)
    ) dut (
        .CLK_IN       (CLK_IN),
        .RST          (RST),
        .bus          (bus)
`ifdef CLOCK_GATE_STATS_EN
        ,
        .GATE_EVENTS  (GATE_EVENTS),
        .GATED_CYCLES (GATED_CYCLES)
`endif
    );

    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK_IN);
            @(negedge CLK_IN);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK_IN);
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int low_seen;
        int req_seen;
        bus.ENABLE    = 1'b1;
        bus.ACTIVITY  = 1'b0;
        bus.SLEEP_ACK = 1'b1;
        RST           = 1'b1;
        @(negedge CLK_IN);
        @(negedge CLK_IN);
        chk("rst_clk_en", bus.CLK_EN, 1);
        chk("rst_ready", bus.CLK_READY, 1);
        chk("rst_req", bus.SLEEP_REQ, 0);
        chk("rst_gated", bus.GATED, 0);
        RST = 1'b0;

        // Idle from reset with SLEEP_ACK held high.
        tick(8);
        chk("a_req_e8", bus.SLEEP_REQ, 0);
        tick();
        chk("a_req_e9", bus.SLEEP_REQ, 1);
        chk("a_en_e9", bus.CLK_EN, 1);
        tick();
        chk("a_en_e10", bus.CLK_EN, 0);
        chk("a_gated_e10", bus.GATED, 1);
        chk("a_ready_e10", bus.CLK_READY, 0);
`ifdef CLOCK_GATE_STATS_EN
        chk("a_events", GATE_EVENTS, 1);
        chk("a_gcyc_e10", GATED_CYCLES, 0);
`endif
        tick();

        // One-cycle activity pulse while gated.
        bus.ACTIVITY = 1'b1;
        tick();
        bus.ACTIVITY = 1'b0;
        chk("b_en_n", bus.CLK_EN, 0);
        tick();
        chk("b_en_n1", bus.CLK_EN, 1);
        chk("b_req_n1", bus.SLEEP_REQ, 0);
        chk("b_gated_n1", bus.GATED, 0);
        chk("b_ready_n1", bus.CLK_READY, 0);
`ifdef CLOCK_GATE_STATS_EN
        chk("b_gcyc", GATED_CYCLES, 3);
`endif
        tick(2);
        chk("b_ready_n3", bus.CLK_READY, 0);
        tick();
        chk("b_ready_n4", bus.CLK_READY, 1);
        chk("b_en_n4", bus.CLK_EN, 1);

        // Re-gate, wake, then reset while in WAKE.
        tick(9);
        chk("c_en_regated", bus.CLK_EN, 0);
        bus.ACTIVITY = 1'b1;
        tick();
        bus.ACTIVITY = 1'b0;
        tick();
        chk("c_ready_wake", bus.CLK_READY, 0);
        RST = 1'b1;
        #1;
        chk("c_rst_en", bus.CLK_EN, 1);
        chk("c_rst_ready", bus.CLK_READY, 1);
        chk("c_rst_req", bus.SLEEP_REQ, 0);
        chk("c_rst_gated", bus.GATED, 0);
`ifdef CLOCK_GATE_STATS_EN
        chk("c_rst_events", GATE_EVENTS, 0);
        chk("c_rst_gcyc", GATED_CYCLES, 0);
`endif
        @(negedge CLK_IN);
        bus.SLEEP_ACK = 1'b0;
        RST = 1'b0;

        // Activity pulse at idle_cnt=5 restarts the idle count.
        tick(5);
        bus.ACTIVITY = 1'b1;
        tick();
        bus.ACTIVITY = 1'b0;
        tick(8);
        chk("d_req_early", bus.SLEEP_REQ, 0);
        tick();
        chk("d_req_late", bus.SLEEP_REQ, 1);

        // Activity and acknowledge together in REQ: abort wins.
        bus.ACTIVITY  = 1'b1;
        bus.SLEEP_ACK = 1'b1;
        tick();
        bus.ACTIVITY = 1'b0;
        chk("e_en_abort", bus.CLK_EN, 1);
        tick();
        chk("e_req_drop", bus.SLEEP_REQ, 0);
        low_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.CLK_EN !== 1'b1) low_seen++;
        end
        chk("e_en_never_low", low_seen, 0);
        tick();
        chk("e_en_regate", bus.CLK_EN, 0);

        // Policy disabled: clock must stay on.
        bus.ENABLE = 1'b0;
        do_reset();
        low_seen = 0;
        req_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.CLK_EN !== 1'b1) low_seen++;
            if (bus.SLEEP_REQ !== 1'b0) req_seen++;
        end
        chk("f_dis_en", low_seen, 0);
        chk("f_dis_req", req_seen, 0);
        bus.ENABLE = 1'b1;
        tick(9);
        chk("f_req_e9", bus.SLEEP_REQ, 1);
        tick();
        chk("f_en_e10", bus.CLK_EN, 0);
        bus.ENABLE = 1'b0;
        tick();
        tick();
        chk("f_en_rise", bus.CLK_EN, 1);
        chk("f_ready_rise", bus.CLK_READY, 0);
        tick(2);
        chk("f_ready_n3", bus.CLK_READY, 0);
        tick();
        chk("f_ready_n4", bus.CLK_READY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
